// File: rtl/m_axi_cmd_pkg.sv
// Shared types and AXI constants for the single-beat AXI command initiator.
package m_axi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/m_axi_cmd_if.sv
// Command/response port plus the AXI AW/W/B/AR/R channels of the initiator.
interface m_axi_cmd_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;
  logic [SW-1:0]         cmd_wstrb_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_write_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic [1:0]            rsp_resp_o;

  logic [3:0]            awid_o;
  logic [3:0]            awlen_o;
  logic [2:0]            awsize_o;
  logic [1:0]            awburst_o;
  logic [ADDR_WIDTH-1:0] awaddr_o;
  logic                  awvalid_o;
  logic                  awready_i;

  logic [3:0]            wid_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic [SW-1:0]         wstrb_o;
  logic                  wlast_o;
  logic                  wvalid_o;
  logic                  wready_i;

  logic [3:0]            bid_i;
  logic [1:0]            bresp_i;
  logic                  bvalid_i;
  logic                  bready_o;

  logic [3:0]            arid_o;
  logic [ADDR_WIDTH-1:0] araddr_o;
  logic                  arvalid_o;
  logic                  arready_i;

  logic [3:0]            rid_i;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic                  rlast_i;
  logic                  rvalid_i;
  logic                  rready_o;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_resp_o,
    input  rsp_ready_i,
    output awid_o, awlen_o, awsize_o, awburst_o, awaddr_o, awvalid_o,
    input  awready_i,
    output wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
    input  wready_i,
    input  bid_i, bresp_i, bvalid_i,
    output bready_o,
    output arid_o, araddr_o, arvalid_o,
    input  arready_i,
    input  rid_i, rdata_i, rlast_i, rvalid_i,
    output rready_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_resp_o,
    output rsp_ready_i,
    input  awid_o, awlen_o, awsize_o, awburst_o, awaddr_o, awvalid_o,
    output awready_i,
    input  wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
    output wready_i,
    output bid_i, bresp_i, bvalid_i,
    input  bready_o,
    input  arid_o, araddr_o, arvalid_o,
    output arready_i,
    output rid_i, rdata_i, rlast_i, rvalid_i,
    input  rready_o
  );

endinterface

// File: rtl/m_axi_cmd.sv
// Single-outstanding AXI initiator: one command in, one AXI beat out,
// outcome returned on the response port.
module m_axi_cmd
  import m_axi_cmd_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] AXI_ID     = 4'h0
) (
  input  logic         clk,
  input  logic         areset,
  m_axi_cmd_if.master  bus,
  output logic         busy_o,
  output logic         id_err_o
);

  localparam int SW = DATA_WIDTH / 8;

  state_t                state;
  state_t                nxt;
  logic                  aw_done;
  logic                  w_done;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic                  id_err_q;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;
  logic accept;
  logic unused_rlast;

  assign aw_hs  = bus.awvalid_o & bus.awready_i;
  assign w_hs   = bus.wvalid_o & bus.wready_i;
  assign b_hs   = bus.bready_o & bus.bvalid_i;
  assign r_hs   = bus.rready_o & bus.rvalid_i;
  assign accept = bus.cmd_ready_o & bus.cmd_valid_i;

  // Last beat is implied by single-beat bursts
  assign unused_rlast = bus.rlast_i;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt             = state;
    bus.cmd_ready_o = 1'b0;
    bus.awvalid_o   = 1'b0;
    bus.wvalid_o    = 1'b0;
    bus.bready_o    = 1'b0;
    bus.arvalid_o   = 1'b0;
    bus.rready_o    = 1'b0;
    bus.rsp_valid_o = 1'b0;
    busy_o          = 1'b1;
    unique case (state)
      IDLE: begin
        bus.cmd_ready_o = 1'b1;
        busy_o          = 1'b0;
        if (bus.cmd_valid_i)
          nxt = bus.cmd_write_i ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        bus.awvalid_o = ~aw_done;
        bus.wvalid_o  = ~w_done;
        if ((aw_done | aw_hs) & (w_done | w_hs)) nxt = WR_RESP;
      end
      WR_RESP: begin
        bus.bready_o = 1'b1;
        if (bus.bvalid_i) nxt = RSP;
      end
      RD_REQ: begin
        bus.arvalid_o = 1'b1;
        if (bus.arready_i) nxt = RD_DATA;
      end
      RD_DATA: begin
        bus.rready_o = 1'b1;
        if (bus.rvalid_i) nxt = RSP;
      end
      RSP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
      id_err_q <= 1'b0;
    end else begin
      if (accept) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        write_q <= bus.cmd_write_i;
        addr_q  <= bus.cmd_addr_i;
        wdata_q <= bus.cmd_wdata_i;
        strb_q  <= bus.cmd_wstrb_i;
        rdata_q <= '0;
        resp_q  <= RESP_OKAY;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        resp_q  <= bus.bresp_i;
        rdata_q <= '0;
        if (bus.bid_i != AXI_ID) id_err_q <= 1'b1;
      end
      if (r_hs) begin
        resp_q  <= RESP_OKAY;
        rdata_q <= bus.rdata_i;
        if (bus.rid_i != AXI_ID) id_err_q <= 1'b1;
      end
    end
  end

  assign bus.awid_o      = AXI_ID;
  assign bus.awlen_o     = 4'd0;
  assign bus.awsize_o    = SIZE_4B;
  assign bus.awburst_o   = BURST_INCR;
  assign bus.awaddr_o    = addr_q;
  assign bus.wid_o       = AXI_ID;
  assign bus.wdata_o     = wdata_q;
  assign bus.wstrb_o     = strb_q;
  assign bus.wlast_o     = 1'b1;
  assign bus.arid_o      = AXI_ID;
  assign bus.araddr_o    = addr_q;
  assign bus.rsp_write_o = write_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_resp_o  = resp_q;
  assign id_err_o        = id_err_q;

endmodule

// File: tb/tb_m_axi_cmd.sv
// Bench for m_axi_cmd: register-slave model on the AXI side, scoreboard
// of expected register contents, latency and handshake-ordering checks.
module tb_m_axi_cmd;
  import m_axi_cmd_pkg::*;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic busy;
  logic id_err;

  always #5 clk = ~clk;

  m_axi_cmd_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  m_axi_cmd #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .AXI_ID(4'h0)) dut (
    .clk      (clk),
    .areset   (areset),
    .bus      (bus),
    .busy_o   (busy),
    .id_err_o (id_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_lat = 0, r_lat = 0;
  logic [3:0] bid_val = 4'h0;
  logic [3:0] rid_val = 4'h0;

  logic [31:0] slv_mem [8];
  logic [31:0] ref_mem [8];

  bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
  bit aw_have, w_have, b_pend, r_pend;
  int aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0]  w_s;
  logic [1:0]  b_resp;

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    logic [31:0] x;
    x = '0;
    if (a < 32'h20) return slv_mem[a[4:2]];
    for (int i = 0; i < 8; i++) x ^= slv_mem[i];
    return x;
  endfunction

  task automatic gen_ready(input logic v, input int d, inout int wt,
                           output logic rdy);
    if (v) begin
      if (wt >= d) rdy = 1'b1;
      else begin
        rdy = 1'b0;
        wt++;
      end
    end else begin
      rdy = 1'b0;
      wt  = 0;
    end
  endtask

  // Register slave: readies/valids driven on the falling edge
  initial begin
    for (int i = 0; i < 8; i++) slv_mem[i] = '0;
    bus.awready_i = 0; bus.wready_i = 0; bus.arready_i = 0;
    bus.bvalid_i = 0; bus.bid_i = 0; bus.bresp_i = 0;
    bus.rvalid_i = 0; bus.rid_i = 0; bus.rdata_i = 0; bus.rlast_i = 0;
    forever begin
      @(negedge clk);
      if (areset) begin
        {aw_fire, w_fire, b_fire, ar_fire, r_fire} = '0;
        {aw_have, w_have, b_pend, r_pend} = '0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        bus.awready_i = 0; bus.wready_i = 0; bus.arready_i = 0;
        bus.bvalid_i = 0; bus.rvalid_i = 0;
      end else begin
        if (aw_fire) aw_have = 1;
        if (w_fire)  w_have  = 1;
        if (b_fire) begin bus.bvalid_i = 0; b_pend = 0; end
        if (r_fire) begin bus.rvalid_i = 0; r_pend = 0; end
        if (ar_fire) begin
          r_pend = 1; r_cnt = r_lat; bus.rdata_i = slv_read(ar_a);
        end
        if (aw_have && w_have) begin
          if (aw_a < 32'h20) begin
            for (int b = 0; b < 4; b++)
              if (w_s[b]) slv_mem[aw_a[4:2]][8*b +: 8] = w_d[8*b +: 8];
            b_resp = RESP_OKAY;
          end else b_resp = RESP_SLVERR;
          b_pend = 1; b_cnt = b_lat; aw_have = 0; w_have = 0;
        end
        if (b_pend && !bus.bvalid_i) begin
          if (b_cnt == 0) begin
            bus.bvalid_i = 1; bus.bid_i = bid_val; bus.bresp_i = b_resp;
          end else b_cnt--;
        end
        if (r_pend && !bus.rvalid_i) begin
          if (r_cnt == 0) begin
            bus.rvalid_i = 1; bus.rid_i = rid_val; bus.rlast_i = 1;
          end else r_cnt--;
        end
        gen_ready(bus.awvalid_o, aw_delay, aw_wait, bus.awready_i);
        gen_ready(bus.wvalid_o, w_delay, w_wait, bus.wready_i);
        gen_ready(bus.arvalid_o, ar_delay, ar_wait, bus.arready_i);
        aw_fire = bus.awvalid_o && bus.awready_i;
        w_fire  = bus.wvalid_o && bus.wready_i;
        ar_fire = bus.arvalid_o && bus.arready_i;
        b_fire  = bus.bvalid_i && bus.bready_o;
        r_fire  = bus.rvalid_i && bus.rready_o;
        if (aw_fire) aw_a = bus.awaddr_o;
        if (w_fire) begin w_d = bus.wdata_o; w_s = bus.wstrb_o; end
        if (ar_fire) ar_a = bus.araddr_o;
      end
    end
  end

  // Reference: what the register file should hold and return
  task automatic model_write(input logic [31:0] a, d, input logic [3:0] s,
                             output logic [1:0] resp);
    int idx;
    idx = int'(a / 4);
    if (idx < 8) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      resp = 2'b00;
    end else resp = 2'b10;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] x;
    if (a / 4 < 8) return ref_mem[a / 4];
    x = 0;
    foreach (ref_mem[i]) x = x ^ ref_mem[i];
    return x;
  endfunction

  task automatic run_cmd(input bit wr, input logic [31:0] a, d,
                         input logic [3:0] s, output logic [31:0] rd,
                         output logic [1:0] rs, output int lat,
                         output int aw_k, output int w_k);
    bit bad, bad2, ok;
    logic pv_aw, pv_w, pv_ar;
    logic [31:0] pa_aw, pa_ar, pd_w;
    logic [3:0] ps_w;
    bad = 0; bad2 = 0;
    @(negedge clk);
    bus.cmd_valid_i = 1; bus.cmd_write_i = wr;
    bus.cmd_addr_i = a; bus.cmd_wdata_i = d; bus.cmd_wstrb_i = s;
    @(posedge clk); #1;
    bus.cmd_valid_i = 0;
    bus.cmd_addr_i = $urandom; bus.cmd_wdata_i = $urandom;
    n_tests++;
    if (wr) ok = bus.awvalid_o && bus.wvalid_o && bus.awaddr_o == a &&
                 bus.wdata_o == d && bus.wstrb_o == s && !bus.arvalid_o;
    else    ok = bus.arvalid_o && bus.araddr_o == a && !bus.awvalid_o;
    if (!ok) begin
      n_fail++;
      $display("FAIL first_beat: aw=%b w=%b ar=%b required wr=%b",
               bus.awvalid_o, bus.wvalid_o, bus.arvalid_o, wr);
    end
    lat = 0; aw_k = -1; w_k = -1;
    while (!bus.rsp_valid_o && lat < 200) begin
      pv_aw = bus.awvalid_o; pa_aw = bus.awaddr_o;
      pv_w = bus.wvalid_o; pd_w = bus.wdata_o; ps_w = bus.wstrb_o;
      pv_ar = bus.arvalid_o; pa_ar = bus.araddr_o;
      @(posedge clk); #1;
      lat++;
      if (pv_aw && bus.awready_i) aw_k = lat;
      else if (pv_aw && (!bus.awvalid_o || bus.awaddr_o != pa_aw)) bad = 1;
      if (pv_w && bus.wready_i) w_k = lat;
      else if (pv_w && (!bus.wvalid_o || bus.wdata_o != pd_w ||
                        bus.wstrb_o != ps_w)) bad = 1;
      if (pv_ar && !bus.arready_i &&
          (!bus.arvalid_o || bus.araddr_o != pa_ar)) bad = 1;
      if (!bus.rsp_valid_o && (bus.cmd_ready_o || !busy)) bad = 1;
    end
    n_tests++;
    if (!bus.rsp_valid_o) begin
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", bus.rsp_valid_o);
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL axi_hold: valid/payload changed before handshake");
    end
    rd = bus.rsp_rdata_o; rs = bus.rsp_resp_o;
    n_tests++;
    if (bus.rsp_write_o !== wr) begin
      n_fail++;
      $display("FAIL rsp_write: got %b required %b", bus.rsp_write_o, wr);
    end
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      if (!bus.rsp_valid_o || bus.rsp_rdata_o !== rd ||
          bus.rsp_resp_o !== rs) bad2 = 1;
    end
    @(negedge clk); bus.rsp_ready_i = 1;
    @(posedge clk); #1; bus.rsp_ready_i = 0;
    n_tests++;
    if (bad2 || bus.rsp_valid_o || !bus.cmd_ready_o || busy) begin
      n_fail++;
      $display("FAIL rsp_handshake: hold_err=%b valid=%b ready=%b busy=%b",
               bad2, bus.rsp_valid_o, bus.cmd_ready_o, busy);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    logic [6:0] v;
    v = {bus.awvalid_o, bus.wvalid_o, bus.bready_o, bus.arvalid_o,
         bus.rready_o, bus.rsp_valid_o, busy};
    n_tests++;
    if (v !== 7'b0 || bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ctrl: valids=%b cmd_ready=%b required 0/1",
               tag, v, bus.cmd_ready_o);
    end
    n_tests++;
    if (id_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_id_err: got %b required 0", tag, id_err);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_idle_outputs("reset");
    n_tests++;
    if ({bus.awaddr_o, bus.araddr_o, bus.wdata_o, bus.rsp_rdata_o} !== '0 ||
        bus.wstrb_o !== 4'h0 || bus.rsp_resp_o !== 2'b00 ||
        bus.rsp_write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: awaddr=%h wdata=%h rdata=%h required 0",
               bus.awaddr_o, bus.wdata_o, bus.rsp_rdata_o);
    end
    repeat (2) @(posedge clk);
    #2 areset = 0;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] rd, erd,
                           input logic [1:0] rs, ers, input int lat, elat);
    n_tests++;
    if (rd !== erd || rs !== ers) begin
      n_fail++;
      $display("FAIL %s_data: got %h/%b required %h/%b", tag, rd, rs, erd, ers);
    end
    n_tests++;
    if (lat != elat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d required %0d", tag, lat, elat);
    end
  endtask

  task automatic test_write_read_basic();
    logic [31:0] rd; logic [1:0] rs, ers; int lat, awk, wk;
    model_write(32'h4, 32'hDEADBEEF, 4'hF, ers);
    run_cmd(1, 32'h4, 32'hDEADBEEF, 4'hF, rd, rs, lat, awk, wk);
    check_rsp("wr_basic", rd, 32'h0, rs, ers, lat, 2);
    n_tests++;
    if (awk != 1 || wk != 1) begin
      n_fail++;
      $display("FAIL wr_basic_aw_w: got aw=%0d w=%0d required 1/1", awk, wk);
    end
    run_cmd(0, 32'h4, 32'h0, 4'h0, rd, rs, lat, awk, wk);
    check_rsp("rd_basic", rd, model_read(32'h4), rs, 2'b00, lat, 2);
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic [1:0] rs, ers; int lat, awk, wk;
    model_write(32'h40, 32'h12345678, 4'hF, ers);
    run_cmd(1, 32'h40, 32'h12345678, 4'hF, rd, rs, lat, awk, wk);
    check_rsp("wr_oor", rd, 32'h0, rs, ers, lat, 2);
  endtask

  task automatic test_xor_readback();
    logic [31:0] rd; logic [1:0] rs, ers; int lat, awk, wk;
    for (int i = 0; i < 8; i++) begin
      model_write(32'(i * 4), 32'(i + 1), 4'hF, ers);
      run_cmd(1, 32'(i * 4), 32'(i + 1), 4'hF, rd, rs, lat, awk, wk);
    end
    run_cmd(0, 32'h20, 32'h0, 4'h0, rd, rs, lat, awk, wk);
    check_rsp("rd_xor", rd, model_read(32'h20), rs, 2'b00, lat, 2);
  endtask

  task automatic test_aw_delay_id_err();
    logic [31:0] rd, d; logic [1:0] rs, ers; int lat, awk, wk;
    aw_delay = 3; w_delay = 0; bid_val = 4'h5;
    d = $urandom;
    model_write(32'h8, d, 4'hF, ers);
    run_cmd(1, 32'h8, d, 4'hF, rd, rs, lat, awk, wk);
    check_rsp("wr_awdly", rd, 32'h0, rs, ers, lat, 5);
    n_tests++;
    if (awk != 4 || wk != 1) begin
      n_fail++;
      $display("FAIL awdly_order: got aw=%0d w=%0d required 4/1", awk, wk);
    end
    n_tests++;
    if (id_err !== 1'b1) begin
      n_fail++;
      $display("FAIL id_err_set: got %b required 1", id_err);
    end
    aw_delay = 0; bid_val = 4'h0;
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, erd; logic [1:0] rs, ers; logic [3:0] s;
    int lat, awk, wk, elat; bit wr;
    for (int n = 0; n < 30; n++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3);
      b_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      wr = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15) * 4);
      d = $urandom; s = 4'($urandom_range(0, 15));
      if (wr) begin
        model_write(a, d, s, ers);
        erd = 0;
        elat = 2 + (aw_delay > w_delay ? aw_delay : w_delay) + b_lat;
      end else begin
        erd = model_read(a); ers = 2'b00;
        elat = 2 + ar_delay + r_lat;
      end
      run_cmd(wr, a, d, s, rd, rs, lat, awk, wk);
      check_rsp(wr ? "rand_wr" : "rand_rd", rd, erd, rs, ers, lat, elat);
    end
    n_tests++;
    if (id_err !== 1'b1) begin
      n_fail++;
      $display("FAIL id_err_sticky: got %b required 1", id_err);
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_lat = 0; r_lat = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rs; int lat, awk, wk, t;
    b_lat = 4;
    @(negedge clk);
    bus.cmd_valid_i = 1; bus.cmd_write_i = 1;
    bus.cmd_addr_i = 32'h40; bus.cmd_wdata_i = $urandom; bus.cmd_wstrb_i = 4'hF;
    @(posedge clk); #1; bus.cmd_valid_i = 0;
    t = 0;
    while (!bus.bready_o && t < 20) begin
      @(posedge clk); #1; t++;
    end
    n_tests++;
    if (!bus.bready_o) begin
      n_fail++;
      $display("FAIL mid_reach_wr_resp: bready=%b required 1", bus.bready_o);
    end
    areset = 1;
    #1;
    check_idle_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #2 areset = 0;
    b_lat = 0;
    run_cmd(0, 32'hC, 32'h0, 4'h0, rd, rs, lat, awk, wk);
    check_rsp("post_reset_rd", rd, model_read(32'hC), rs, 2'b00, lat, 2);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    bus.cmd_valid_i = 0; bus.cmd_write_i = 0; bus.cmd_addr_i = 0;
    bus.cmd_wdata_i = 0; bus.cmd_wstrb_i = 0; bus.rsp_ready_i = 0;
    test_reset();
    test_write_read_basic();
    test_out_of_range();
    test_xor_readback();
    test_aw_delay_id_err();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/m_axi_cmd.md
# m_axi_cmd

Single-outstanding AXI initiator that turns one command (write or read, one 32-bit beat) into a full AXI transaction and returns the outcome on a response port. It sits between test/control logic and the AXI register slave (8 registers at byte offsets 0x00–0x1C; any higher index reads back the XOR of all eight), driving its AW/W/B and AR/R channels from the other end.

## Interface
- DATA_WIDTH, 32, data bus width; strobe width is DATA_WIDTH/8.
- ADDR_WIDTH, 32, address width.
- AXI_ID, 4'h0, ID driven on awid_o/wid_o/arid_o and expected on bid_i/rid_i.
- clk  in  1  clock, all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  byte address.
- cmd_wdata_i / cmd_wstrb_i  in  DATA_WIDTH / DATA_WIDTH/8  write data and byte strobes; ignored for reads.
- rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake.
- rsp_write_o  out  1  echoes the command type.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp_o  out  2  captured bresp_i or rresp.
- AW channel  out: awid_o[3:0], awlen_o[3:0], awsize_o[2:0], awburst_o[1:0], awaddr_o, awvalid_o; in: awready_i.
- W channel  out: wid_o[3:0], wdata_o, wstrb_o, wlast_o, wvalid_o; in: wready_i.
- B channel  in: bid_i[3:0], bresp_i[1:0], bvalid_i; out: bready_o.
- AR channel  out: arid_o[3:0], araddr_o, arvalid_o; in: arready_i.
- R channel  in: rid_i[3:0], rdata_i, rlast_i, rvalid_i; out: rready_o.
- busy_o  out  1  high in every state except IDLE.
- id_err_o  out  1  sticky; set when bid_i/rid_i differs from AXI_ID at handshake.

## Operation
- Constants: awlen_o = 0, awsize_o = 3'b010, awburst_o = 2'b01 (INCR), wlast_o = 1, all IDs = AXI_ID.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready_o = 1. On cmd_valid_i: latch addr/data/strb/type; go to WR_REQ (write) or RD_REQ (read).
- WR_REQ: awvalid_o and wvalid_o asserted together; each dropped independently after its own handshake (aw_done, w_done flags). When both done → WR_RESP. AW and W handshakes in the same cycle or in either order are legal.
- WR_RESP: bready_o = 1; on bvalid_i capture bresp_i, check bid_i → RSP.
- RD_REQ: arvalid_o = 1 until arready_i → RD_DATA.
- RD_DATA: rready_o = 1; on rvalid_i capture rdata_i, resp = 2'b00, check rid_i → RSP. rlast_i not checked.
- RSP: rsp_valid_o = 1 with fields stable; on rsp_ready_i → IDLE.
- Only one transaction outstanding; no new command accepted outside IDLE.
- id_err_o cleared only by reset.

## Timing
- Reset: state IDLE; cmd_ready_o = 1; all other outputs 0 (valids, readies, rsp fields, id_err_o, busy_o); address/data outputs 0.
- All AXI outputs registered; no combinational path from any *_i to any AXI *_o.
- Command accepted at edge N → awvalid_o/wvalid_o (or arvalid_o) high from cycle N+1.
- With a slave that is always ready: write rsp_valid_o at N+1 + (AW/W handshake) + (B latency) + 1; read similarly.
- Valid signals and their payload are held stable until the handshake (AXI rule); never withdrawn.
- bready_o/rready_o high only in WR_RESP/RD_DATA; a B/R beat arriving earlier is not accepted.
- areset mid-transaction: immediate return to reset values; in-flight transaction abandoned.

## Structure
- Package m_axi_cmd_pkg: state enum, BURST_INCR, SIZE_4B, RESP_OKAY/SLVERR constants.
- Single module; no sub-module.

## Test plan
- Write 0x00000004, data 0xDEADBEEF, strb 0xF, slave always ready → AW/W together one cycle after accept, rsp_resp_o = 0, rsp_write_o = 1.
- Read 0x00000004 after above → rsp_rdata_o = 0xDEADBEEF, rsp_resp_o = 0.
- Write 0x40 (out of range) → rsp_resp_o = 2'b10 captured from slave.
- Write 0x00..0x1C with 1..8, read 0x20 → rsp_rdata_o = 0x00000008 (XOR of 1..8).
- awready_i delayed 3 cycles, wready_i immediate → wvalid_o drops after 1 cycle, awvalid_o held, payload stable; bid_i = 4'h5 with AXI_ID = 0 → id_err_o = 1.
- areset during WR_RESP → all valids/readies 0 same cycle, cmd_ready_o = 1, next command completes normally.
